ex_mm_stage: RTL and testbench



---
 rtl/ex_mm_stage.sv | 194 +++++++++++++++++++
 tb/tb_ex_mm_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mm_stage.sv
// ex_mm_stage: EX->MEM pipeline stage register with valid/ready handshake.
//
// Each held entry carries the writeback address, enable and data, the
// memory-op code and the store data. Writes to x0 are suppressed when an
// entry is captured, so they never reach MEM or the forwarding tap.
//
// Build option (macro EX_MM_SKID_EN):
//   undefined : one entry; ex_ready = !mm_valid | mm_ready (combinational
//               from mm_ready), and a drain plus an accept on the same edge
//               replace the head.
//   defined   : two entries (head + skid); ex_ready comes straight from a
//               register, which cuts the upstream ready path.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous kill of all held entries; wins over accept
//   ex_valid/ex_ready upstream handshake
//   ex_wa/we/wn/mop/sdata   incoming instruction fields
//   mm_valid/mm_ready downstream handshake (head entry)
//   mm_wa/we/wn/mop/sdata   head entry fields; we/mop read 0 when invalid
//   fwd_we/fwd_wa/fwd_wn    forwarding tap for the EX operand bypass
module ex_mm_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int MOPW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [AW-1:0]   ex_wa,
    input  logic            ex_we,
    input  logic [DW-1:0]   ex_wn,
    input  logic [MOPW-1:0] ex_mop,
    input  logic [DW-1:0]   ex_sdata,
    output logic            mm_valid,
    input  logic            mm_ready,
    output logic [AW-1:0]   mm_wa,
    output logic            mm_we,
    output logic [DW-1:0]   mm_wn,
    output logic [MOPW-1:0] mm_mop,
    output logic [DW-1:0]   mm_sdata,
    output logic            fwd_we,
    output logic [AW-1:0]   fwd_wa,
    output logic [DW-1:0]   fwd_wn
);

    typedef struct packed {
        logic [AW-1:0]   wa;
        logic            we;
        logic [DW-1:0]   wn;
        logic [MOPW-1:0] mop;
        logic [DW-1:0]   sdata;
    } entry_t;

    localparam int EW = AW + 1 + DW + MOPW + DW;

    // An emptied slot keeps its address/data but must not request a write
    // or a memory access, so only the control fields are cleared.
    function automatic entry_t kill_ctl(input entry_t e);
        entry_t r;
        r     = e;
        r.we  = 1'b0;
        r.mop = {MOPW{1'b0}};
        return r;
    endfunction

    entry_t in_s;
    entry_t head_r;
    logic   head_valid_r;
    logic   ex_ready_s;
    logic   accept_s;
    logic   drain_s;

    // Incoming entry, with the x0 write dropped at capture time.
    always_comb begin
        in_s.wa    = ex_wa;
        in_s.we    = ex_we & (ex_wa != {AW{1'b0}});
        in_s.wn    = ex_wn;
        in_s.mop   = ex_mop;
        in_s.sdata = ex_sdata;
    end

    assign accept_s = ex_valid & ex_ready_s;
    assign drain_s  = head_valid_r & mm_ready;

`ifdef EX_MM_SKID_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_r;
    entry_t skid_r;
    logic   ex_ready_r;

    assign ex_ready_s = ex_ready_r;

    // Head/skid FSM; ex_ready_r is low exactly while the skid slot is full.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_EMPTY;
            ex_ready_r   <= 1'b1;
            head_valid_r <= 1'b0;
            head_r       <= entry_t'({EW{1'b0}});
            skid_r       <= entry_t'({EW{1'b0}});
        end else if (flush) begin
            state_r      <= ST_EMPTY;
            ex_ready_r   <= 1'b1;
            head_valid_r <= 1'b0;
            head_r       <= kill_ctl(head_r);
            skid_r       <= kill_ctl(skid_r);
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        head_r       <= in_s;
                        head_valid_r <= 1'b1;
                        state_r      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_s && !drain_s) begin
                        // Head is stalled: park the newcomer and close the gate.
                        skid_r     <= in_s;
                        ex_ready_r <= 1'b0;
                        state_r    <= ST_FULL;
                    end else if (accept_s && drain_s) begin
                        head_r <= in_s;
                    end else if (drain_s) begin
                        head_r       <= kill_ctl(head_r);
                        head_valid_r <= 1'b0;
                        state_r      <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // No accept here: ex_ready_r is 0 in this state.
                    if (drain_s) begin
                        head_r     <= skid_r;
                        skid_r     <= kill_ctl(skid_r);
                        ex_ready_r <= 1'b1;
                        state_r    <= ST_ONE;
                    end
                end
                default: begin
                    state_r      <= ST_EMPTY;
                    ex_ready_r   <= 1'b1;
                    head_valid_r <= 1'b0;
                    head_r       <= kill_ctl(head_r);
                    skid_r       <= kill_ctl(skid_r);
                end
            endcase
        end
    end

`else

    assign ex_ready_s = ~head_valid_r | mm_ready;

    // Single head slot; accept has priority over drain so that a
    // simultaneous drain+accept replaces the head in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid_r <= 1'b0;
            head_r       <= entry_t'({EW{1'b0}});
        end else if (flush) begin
            head_valid_r <= 1'b0;
            head_r       <= kill_ctl(head_r);
        end else if (accept_s) begin
            head_valid_r <= 1'b1;
            head_r       <= in_s;
        end else if (drain_s) begin
            head_valid_r <= 1'b0;
            head_r       <= kill_ctl(head_r);
        end
    end

`endif

    assign ex_ready = ex_ready_s;
    assign mm_valid = head_valid_r;
    assign mm_wa    = head_r.wa;
    assign mm_we    = head_r.we;
    assign mm_wn    = head_r.wn;
    assign mm_mop   = head_r.mop;
    assign mm_sdata = head_r.sdata;
    assign fwd_we   = head_valid_r & head_r.we;
    assign fwd_wa   = head_r.wa;
    assign fwd_wn   = head_r.wn;

endmodule

// File: tb/tb_ex_mm_stage.sv
// Directed testbench for ex_mm_stage. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point (registered values
// after the edge) or one more unit later for the combinational ex_ready.
module tb_ex_mm_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_wa;
    logic        ex_we;
    logic [31:0] ex_wn;
    logic [3:0]  ex_mop;
    logic [31:0] ex_sdata;
    logic        mm_valid;
    logic        mm_ready;
    logic [4:0]  mm_wa;
    logic        mm_we;
    logic [31:0] mm_wn;
    logic [3:0]  mm_mop;
    logic [31:0] mm_sdata;
    logic        fwd_we;
    logic [4:0]  fwd_wa;
    logic [31:0] fwd_wn;

    int n_tests = 0;
    int n_fail  = 0;

    ex_mm_stage #(.DW(32), .AW(5), .MOPW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ex_valid (ex_valid),
        .ex_ready (ex_ready),
        .ex_wa    (ex_wa),
        .ex_we    (ex_we),
        .ex_wn    (ex_wn),
        .ex_mop   (ex_mop),
        .ex_sdata (ex_sdata),
        .mm_valid (mm_valid),
        .mm_ready (mm_ready),
        .mm_wa    (mm_wa),
        .mm_we    (mm_we),
        .mm_wn    (mm_wn),
        .mm_mop   (mm_mop),
        .mm_sdata (mm_sdata),
        .fwd_we   (fwd_we),
        .fwd_wa   (fwd_wa),
        .fwd_wn   (fwd_wn)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wa, input logic we,
                         input logic [31:0] wn, input logic [3:0] mop, input logic [31:0] sd);
        ex_valid = v;
        ex_wa    = wa;
        ex_we    = we;
        ex_wn    = wn;
        ex_mop   = mop;
        ex_sdata = sd;
    endtask

    task automatic expect_head(input string tag, input logic [4:0] wa, input logic [31:0] wn);
        check_eq({tag, ".valid"}, 32'(mm_valid), 32'd1);
        check_eq({tag, ".wa"},    32'(mm_wa),    32'(wa));
        check_eq({tag, ".wn"},    mm_wn,         wn);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        mm_ready = 1'b0;
        drive(1'b1, 5'd3, 1'b1, 32'h0000_0055, 4'h1, 32'h0000_0077);

        // Reset held two cycles with ex_valid high
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq("rst.mm_valid", 32'(mm_valid), 32'd0);
            check_eq("rst.mm_wn",    mm_wn,         32'd0);
            check_eq("rst.ex_ready", 32'(ex_ready), 32'd1);
            check_eq("rst.fwd_we",   32'(fwd_we),   32'd0);
        end
        rst = 1'b0;
        tick();
        expect_head("first", 5'd3, 32'h0000_0055);
        check_eq("first.we",    32'(mm_we),  32'd1);
        check_eq("first.mop",   32'(mm_mop), 32'd1);
        check_eq("first.sdata", mm_sdata,    32'h0000_0077);
        check_eq("first.fwd_we", 32'(fwd_we), 32'd1);
        check_eq("first.fwd_wa", 32'(fwd_wa), 32'd3);
        check_eq("first.fwd_wn", fwd_wn,      32'h0000_0055);

        // Drain: we/mop/fwd_we drop, data holds
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        mm_ready = 1'b1;
        tick();
        check_eq("drain.valid",  32'(mm_valid), 32'd0);
        check_eq("drain.we",     32'(mm_we),    32'd0);
        check_eq("drain.mop",    32'(mm_mop),   32'd0);
        check_eq("drain.fwd_we", 32'(fwd_we),   32'd0);
        check_eq("drain.wn",     mm_wn,         32'h0000_0055);
        check_eq("drain.sdata",  mm_sdata,      32'h0000_0077);

        // Streaming wa=1..8 with mm_ready held high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i), 1'b1, 32'h100 + 32'(i), 4'h0, 32'(i));
            #1;
            check_eq("stream.ex_ready", 32'(ex_ready), 32'd1);
            tick();
            expect_head("stream", 5'(i), 32'h100 + 32'(i));
            check_eq("stream.fwd_we", 32'(fwd_we), 32'd1);
        end
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        tick();
        check_eq("stream.end", 32'(mm_valid), 32'd0);

        // x0 write suppression
        mm_ready = 1'b0;
        drive(1'b1, 5'd0, 1'b1, 32'hDEAD_BEEF, 4'h0, 32'd0);
        tick();
        check_eq("x0.valid",  32'(mm_valid), 32'd1);
        check_eq("x0.we",     32'(mm_we),    32'd0);
        check_eq("x0.fwd_we", 32'(fwd_we),   32'd0);
        check_eq("x0.wn",     mm_wn,         32'hDEAD_BEEF);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        mm_ready = 1'b1;
        tick();
        check_eq("x0.drain", 32'(mm_valid), 32'd0);

        // Backpressure: A, B, C while mm_ready is low
        mm_ready = 1'b0;
        drive(1'b1, 5'd10, 1'b1, 32'h0000_00A0, 4'h2, 32'h0000_0A0A);
        tick();
        expect_head("bp.A", 5'd10, 32'h0000_00A0);
        check_eq("bp.A.mop", 32'(mm_mop), 32'd2);
`ifdef EX_MM_SKID_EN
        check_eq("bp.ready_after_A", 32'(ex_ready), 32'd1);
        drive(1'b1, 5'd11, 1'b1, 32'h0000_00B0, 4'h0, 32'd0);
        tick();
        expect_head("bp.A_held", 5'd10, 32'h0000_00A0);
        check_eq("bp.ready_after_B", 32'(ex_ready), 32'd0);
        drive(1'b1, 5'd12, 1'b1, 32'h0000_00C0, 4'h0, 32'd0);
        tick();
        expect_head("bp.A_still", 5'd10, 32'h0000_00A0);
        check_eq("bp.C_waits", 32'(ex_ready), 32'd0);
        mm_ready = 1'b1;
        tick();
        expect_head("bp.B", 5'd11, 32'h0000_00B0);
        check_eq("bp.ready_reopen", 32'(ex_ready), 32'd1);
        tick();
        expect_head("bp.C", 5'd12, 32'h0000_00C0);
`else
        drive(1'b1, 5'd11, 1'b1, 32'h0000_00B0, 4'h0, 32'd0);
        #1;
        check_eq("bp.ready_held", 32'(ex_ready), 32'd0);
        tick();
        expect_head("bp.A_held", 5'd10, 32'h0000_00A0);
        mm_ready = 1'b1;
        #1;
        check_eq("bp.ready_comb", 32'(ex_ready), 32'd1);
        tick();
        expect_head("bp.B", 5'd11, 32'h0000_00B0);
        drive(1'b1, 5'd12, 1'b1, 32'h0000_00C0, 4'h0, 32'd0);
        tick();
        expect_head("bp.C", 5'd12, 32'h0000_00C0);
`endif
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        tick();
        check_eq("bp.empty", 32'(mm_valid), 32'd0);

        // Flush with a concurrent input that must be dropped
        mm_ready = 1'b0;
        drive(1'b1, 5'd20, 1'b1, 32'h0000_00F0, 4'h3, 32'd0);
        tick();
        expect_head("fl.hold", 5'd20, 32'h0000_00F0);
`ifdef EX_MM_SKID_EN
        drive(1'b1, 5'd21, 1'b1, 32'h0000_00F1, 4'h0, 32'd0);
        tick();
        check_eq("fl.full", 32'(ex_ready), 32'd0);
`endif
        flush    = 1'b1;
        mm_ready = 1'b1;
        drive(1'b1, 5'd22, 1'b1, 32'h0000_00F2, 4'h1, 32'd0);
`ifndef EX_MM_SKID_EN
        #1;
        check_eq("fl.ready_ungated", 32'(ex_ready), 32'd1);
`endif
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        check_eq("fl.valid",    32'(mm_valid), 32'd0);
        check_eq("fl.fwd_we",   32'(fwd_we),   32'd0);
        check_eq("fl.mop",      32'(mm_mop),   32'd0);
        check_eq("fl.ex_ready", 32'(ex_ready), 32'd1);
        tick();
        check_eq("fl.dropped", 32'(mm_valid), 32'd0);
        drive(1'b1, 5'd23, 1'b1, 32'h0000_00F3, 4'h0, 32'd0);
        tick();
        expect_head("fl.next", 5'd23, 32'h0000_00F3);
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        tick();
        check_eq("fl.next_drain", 32'(mm_valid), 32'd0);

        // rst and flush together: reset state, data cleared
        rst   = 1'b1;
        flush = 1'b1;
        drive(1'b1, 5'd24, 1'b1, 32'h0000_00F4, 4'h0, 32'd0);
        tick();
        check_eq("rstfl.valid", 32'(mm_valid), 32'd0);
        check_eq("rstfl.wn",    mm_wn,         32'd0);
        check_eq("rstfl.wa",    32'(mm_wa),    32'd0);
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'd0, 4'h0, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
